// File: rtl/uart_frame_tx.sv
// ============================================================================
// Module  : uart_frame_tx
// Brief   : UART transmitter, LSB-first 8-bit frames with start/stop bits and
//           optional parity (compile with UART_TX_PARITY_EN for 8E/8O frames).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_tx #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int                 c_CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      ,S_PARITY = 3'd4
`endif
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic [2:0]         r_idx;
   logic [2:0]         w_idx_nxt;
   logic [7:0]         r_shreg;
   logic [7:0]         w_shreg_nxt;
   logic               r_tx;
   logic               w_tx_nxt;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               w_done_nxt;
   logic               w_wrap;

`ifdef UART_TX_PARITY_EN
   localparam logic c_PAR_SENSE = (PARITY_ODD != 0);
   logic w_parity;
   assign w_parity = (^r_shreg) ^ c_PAR_SENSE;
`else
   // Parity sense has no meaning without a parity bit
   if (PARITY_ODD != 0) begin : g_parity_odd_ignored
   end
`endif

   assign w_wrap = (r_cnt == c_CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (w_wrap) ? '0 : r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_shreg_nxt = r_shreg;
      w_done_nxt  = 1'b0;
      w_tx_nxt    = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (tx_valid) begin
               w_shreg_nxt = tx_data;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_wrap) begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_wrap) begin
               if (r_idx == 3'd7) begin
                  w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_wrap) begin
               w_state_nxt = S_STOP;
               w_idx_nxt   = '0;
            end
         end
`endif
         S_STOP: begin
            // r_idx counts stop bits here
            if (w_wrap) begin
               if (r_idx == c_STOP_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_idx_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
         end
      endcase

      // Line level is decoded from the next state so tx is a clean register
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shreg_nxt[w_idx_nxt];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_tx_nxt = w_parity;
`endif
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shreg <= '0;
         r_tx    <= 1'b1;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shreg <= w_shreg_nxt;
         r_tx    <= w_tx_nxt;
         r_ready <= (w_state_nxt == S_IDLE);
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
      end
   end

   assign tx         = r_tx;
   assign tx_ready   = r_ready;
   assign busy       = r_busy;
   assign frame_done = r_done;

endmodule

`default_nettype wire
